// File: rtl/cdec8_tx_port.sv
// Memory-mapped serial transmitter: a TX FIFO at BASE_ADRS and a status register at BASE_ADRS+1.
// Frames are 8N1, LSB first, CLKS_PER_BIT clocks per bit.
module cdec8_tx_port #(
   parameter logic [7:0]  BASE_ADRS    = 8'hF0,
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_AW      = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] adrs,
   input  logic [7:0] wr_data,
   input  logic       mmwr_N,
   input  logic       mmrd_N,
   output logic [7:0] rd_data,
   output logic       rd_hit,
   output logic       txd,
   output logic       busy
);

   localparam int unsigned      DEPTH       = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_CNT   = (FIFO_AW + 1)'(DEPTH);
   localparam logic [7:0]       STAT_ADRS   = BASE_ADRS + 8'd1;
   localparam logic [15:0]      BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e               state_q, state_d;
   logic [15:0]          baud_q, baud_d;
   logic [2:0]           bit_q, bit_d;
   logic [7:0]           shreg_q, shreg_d;
   logic                 txd_q, txd_d;
   logic                 wr_prev_q;
   logic                 ovf_q;
   logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]     count_q;
   logic [7:0]           mem [DEPTH];

   logic wr_event, push_req, push, pop;
   logic fifo_full, fifo_empty, baud_end;

   // One event per strobe: only the falling edge of mmwr_N counts.
   assign wr_event   = wr_prev_q & ~mmwr_N;
   assign push_req   = wr_event && (adrs == BASE_ADRS);
   assign fifo_full  = (count_q == DEPTH_CNT);
   assign fifo_empty = (count_q == '0);
   assign push       = push_req & ~fifo_full;
   assign baud_end   = (baud_q == '0);

   assign busy = (state_q != StIdle);
   assign txd  = txd_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_prev_q <= 1'b1;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         wr_prev_q <= mmwr_N;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (push_req && fifo_full) begin
            ovf_q <= 1'b1;
         end else if (wr_event && (adrs == STAT_ADRS)) begin
            ovf_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         txd_q   <= txd_d;
      end
   end

   // txd_d is the line level for the next cycle, so txd comes straight from a flop.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      txd_d   = txd_q;
      pop     = 1'b0;
      case (state_q)
         StIdle: begin
            txd_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shreg_d = mem[rd_ptr_q];
               baud_d  = BAUD_RELOAD;
               state_d = StStart;
               txd_d   = 1'b0;
            end
         end
         StStart: begin
            if (baud_end) begin
               baud_d  = BAUD_RELOAD;
               bit_d   = '0;
               state_d = StData;
               txd_d   = shreg_q[0];
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         StData: begin
            if (baud_end) begin
               baud_d = BAUD_RELOAD;
               if (bit_q == 3'd7) begin
                  state_d = StStop;
                  txd_d   = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shreg_d = {1'b0, shreg_q[7:1]};
                  txd_d   = shreg_q[1];
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         StStop: begin
            if (baud_end) begin
               state_d = StIdle;
               txd_d   = 1'b1;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rd_hit  = 1'b0;
      rd_data = 8'h00;
      if (!mmrd_N) begin
         if (adrs == STAT_ADRS) begin
            rd_hit  = 1'b1;
            rd_data = {ovf_q, 3'b000, fifo_empty, fifo_full, busy, 1'b0};
         end else if (adrs == BASE_ADRS) begin
            rd_hit = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cdec8_tx_port.sv
// Bench for cdec8_tx_port: a line monitor decodes txd into bytes and start times, which are
// compared against a frame-timeline model of the FIFO and shifter.
module tb_cdec8_tx_port;

   localparam int CPB   = 4;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] adrs = 8'h00;
   logic [7:0] wr_data = 8'h00;
   logic       mmwr_N = 1'b1;
   logic       mmrd_N = 1'b1;
   logic [7:0] rd_data;
   logic       rd_hit;
   logic       txd;
   logic       busy;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int cyc      = 0;

   cdec8_tx_port #(
      .BASE_ADRS    (8'hF0),
      .CLKS_PER_BIT (CPB),
      .FIFO_AW      (AW)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .adrs    (adrs),
      .wr_data (wr_data),
      .mmwr_N  (mmwr_N),
      .mmrd_N  (mmrd_N),
      .rd_data (rd_data),
      .rd_hit  (rd_hit),
      .txd     (txd),
      .busy    (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Line monitor: decodes each frame, flags any malformed bit or busy glitch.
   logic [7:0] rx_byte[$];
   int         rx_start[$];
   bit         rx_bad[$];
   bit         mon_active = 1'b0;
   bit         mon_bad;
   int         mon_n;
   int         mon_start;
   int         bit_pos;
   logic [7:0] mon_byte;
   int         idle_bad = 0;

   always @(negedge clock) begin
      if (reset) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (txd === 1'b0) begin
            mon_active = 1'b1;
            mon_n      = 1;
            mon_bad    = (busy !== 1'b1);
            mon_byte   = 8'h00;
            mon_start  = cyc;
         end else if (txd !== 1'b1 || busy !== 1'b0) begin
            idle_bad++;
         end
      end else begin
         bit_pos = mon_n / CPB;
         if (busy !== 1'b1) mon_bad = 1'b1;
         if (bit_pos == 0) begin
            if (txd !== 1'b0) mon_bad = 1'b1;
         end else if (bit_pos <= 8) begin
            if (mon_n % CPB == 0) mon_byte[bit_pos-1] = txd;
            else if (txd !== mon_byte[bit_pos-1]) mon_bad = 1'b1;
         end else if (txd !== 1'b1) begin
            mon_bad = 1'b1;
         end
         mon_n++;
         if (mon_n == FRAME) begin
            rx_byte.push_back(mon_byte);
            rx_start.push_back(mon_start);
            rx_bad.push_back(mon_bad);
            mon_active = 1'b0;
         end
      end
   end

   task automatic clear_rx();
      rx_byte.delete();
      rx_start.delete();
      rx_bad.delete();
   endtask

   // push_edge is the cycle index of the edge that sees the strobe's falling edge.
   task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int len,
                           output int push_edge);
      @(negedge clock);
      adrs      = a;
      wr_data   = d;
      mmwr_N    = 1'b0;
      push_edge = cyc + 1;
      repeat (len) @(negedge clock);
      mmwr_N = 1'b1;
   endtask

   task automatic read_reg(input logic [7:0] a, input logic rd_n, output logic [7:0] d,
                           output logic h);
      @(negedge clock);
      adrs   = a;
      mmrd_N = rd_n;
      #1;
      d      = rd_data;
      h      = rd_hit;
      mmrd_N = 1'b1;
   endtask

   task automatic wait_frames(input int n, input int limit);
      for (int i = 0; i < limit && rx_byte.size() < n; i++) @(negedge clock);
   endtask

   task automatic test_reset();
      logic [7:0] d;
      logic       h;
      repeat (3) @(negedge clock);
      chk_cnt++;
      if ({txd, busy} !== 2'b10) $display("FAIL reset_line: got %b expected 10", {txd, busy});
      else pass_cnt++;
      read_reg(8'hF1, 1'b0, d, h);
      chk_cnt++;
      if ({h, d} !== 9'h108) $display("FAIL reset_status: got %h expected 108", {h, d});
      else pass_cnt++;
      @(negedge clock);
      #2 reset = 1'b0;
      repeat (3) @(negedge clock);
      read_reg(8'hF1, 1'b0, d, h);
      chk_cnt++;
      if ({h, d} !== 9'h108) $display("FAIL post_reset_status: got %h expected 108", {h, d});
      else pass_cnt++;
   endtask

   task automatic test_single();
      int p;
      clear_rx();
      do_write(8'hF0, 8'hA5, 1, p);
      chk_cnt++;
      if ({txd, busy} !== 2'b10) $display("FAIL single_push_edge: got %b expected 10", {txd, busy});
      else pass_cnt++;
      @(negedge clock);
      chk_cnt++;
      if ({txd, busy} !== 2'b01) $display("FAIL single_start: got %b expected 01", {txd, busy});
      else pass_cnt++;
      wait_frames(1, 3 * FRAME);
      repeat (10) @(negedge clock);
      chk_cnt++;
      if (rx_byte.size() != 1) $display("FAIL single_count: got %0d expected 1", rx_byte.size());
      else pass_cnt++;
      if (rx_byte.size() > 0) begin
         chk_cnt++;
         if ({rx_bad[0], rx_byte[0]} !== 9'h0A5)
            $display("FAIL single_frame: got bad=%0d data=%h expected bad=0 data=a5",
                     rx_bad[0], rx_byte[0]);
         else pass_cnt++;
         chk_cnt++;
         if (rx_start[0] != p + 1)
            $display("FAIL single_latency: got %0d expected %0d", rx_start[0], p + 1);
         else pass_cnt++;
      end
   endtask

   task automatic test_long_strobe();
      int p;
      clear_rx();
      do_write(8'hF0, 8'h55, 10, p);
      repeat (3 * FRAME) @(negedge clock);
      chk_cnt++;
      if (rx_byte.size() != 1) $display("FAIL long_strobe_count: got %0d expected 1", rx_byte.size());
      else pass_cnt++;
      if (rx_byte.size() > 0) begin
         chk_cnt++;
         if ({rx_bad[0], rx_byte[0], rx_start[0] == p + 1} !== {1'b0, 8'h55, 1'b1})
            $display("FAIL long_strobe_frame: got data=%h start=%0d expected 55 start=%0d",
                     rx_byte[0], rx_start[0], p + 1);
         else pass_cnt++;
      end
   endtask

   // Six rapid writes: one goes straight to the shifter, four fill the FIFO, one is dropped.
   task automatic test_back_to_back();
      logic [7:0] sent[6];
      logic [7:0] d;
      logic       h;
      int         p0, p;
      clear_rx();
      for (int i = 0; i < 6; i++) begin
         sent[i] = 8'($urandom);
         do_write(8'hF0, sent[i], 1, p);
         if (i == 0) p0 = p;
      end
      read_reg(8'hF1, 1'b0, d, h);
      chk_cnt++;
      if ({h, d} !== 9'h186) $display("FAIL ovf_status: got %h expected 186", {h, d});
      else pass_cnt++;
      do_write(8'hF1, 8'($urandom), 1, p);
      read_reg(8'hF1, 1'b0, d, h);
      chk_cnt++;
      if ({h, d} !== 9'h106) $display("FAIL ovf_clear: got %h expected 106", {h, d});
      else pass_cnt++;
      wait_frames(5, 7 * FRAME);
      repeat (FRAME + 10) @(negedge clock);
      chk_cnt++;
      if (rx_byte.size() != 5) $display("FAIL b2b_count: got %0d expected 5", rx_byte.size());
      else pass_cnt++;
      for (int i = 0; i < 5 && i < rx_byte.size(); i++) begin
         chk_cnt++;
         if ({rx_bad[i], rx_byte[i]} !== {1'b0, sent[i]})
            $display("FAIL b2b_frame%0d: got bad=%0d data=%h expected bad=0 data=%h",
                     i, rx_bad[i], rx_byte[i], sent[i]);
         else pass_cnt++;
         chk_cnt++;
         if (rx_start[i] != p0 + 1 + i * (FRAME + 1))
            $display("FAIL b2b_start%0d: got %0d expected %0d", i, rx_start[i],
                     p0 + 1 + i * (FRAME + 1));
         else pass_cnt++;
      end
      read_reg(8'hF1, 1'b0, d, h);
      chk_cnt++;
      if ({h, d} !== 9'h108) $display("FAIL b2b_final_status: got %h expected 108", {h, d});
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      logic       h;
      int         p;
      clear_rx();
      do_write(8'hF0, 8'h00, 1, p);
      do_write(8'hF0, 8'h00, 1, p);
      do_write(8'hF0, 8'hFF, 1, p);
      repeat (2 * CPB) @(negedge clock);
      chk_cnt++;
      if ({txd, busy} !== 2'b01) $display("FAIL mid_pre_reset: got %b expected 01", {txd, busy});
      else pass_cnt++;
      #2 reset = 1'b1;
      #1;
      chk_cnt++;
      if ({txd, busy} !== 2'b10) $display("FAIL mid_reset_line: got %b expected 10", {txd, busy});
      else pass_cnt++;
      read_reg(8'hF1, 1'b0, d, h);
      chk_cnt++;
      if ({h, d} !== 9'h108) $display("FAIL mid_reset_status: got %h expected 108", {h, d});
      else pass_cnt++;
      @(negedge clock);
      #2 reset = 1'b0;
      repeat (3 * FRAME) @(negedge clock);
      chk_cnt++;
      if (rx_byte.size() != 0) $display("FAIL mid_reset_frames: got %0d expected 0", rx_byte.size());
      else pass_cnt++;
      read_reg(8'hF1, 1'b0, d, h);
      chk_cnt++;
      if ({h, d} !== 9'h108) $display("FAIL mid_reset_after: got %h expected 108", {h, d});
      else pass_cnt++;
   endtask

   task automatic test_read_decode();
      logic [7:0] d;
      logic       h;
      logic [7:0] a;
      read_reg(8'hF2, 1'b0, d, h);
      chk_cnt++;
      if ({h, d} !== 9'h000) $display("FAIL read_f2: got %h expected 000", {h, d});
      else pass_cnt++;
      read_reg(8'hF1, 1'b1, d, h);
      chk_cnt++;
      if ({h, d} !== 9'h000) $display("FAIL read_no_strobe: got %h expected 000", {h, d});
      else pass_cnt++;
      read_reg(8'hF0, 1'b0, d, h);
      chk_cnt++;
      if ({h, d} !== 9'h100) $display("FAIL read_txdata: got %h expected 100", {h, d});
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         a = 8'($urandom_range(0, 239));
         read_reg(a, 1'b0, d, h);
         chk_cnt++;
         if ({h, d} !== 9'h000) $display("FAIL read_other_%h: got %h expected 000", a, {h, d});
         else pass_cnt++;
      end
   endtask

   // Timeline model: a byte pushed at edge p is accepted if fewer than DEPTH accepted bytes are
   // still unpopped at p; it pops at max(p+1, previous pop + FRAME + 1).
   task automatic test_random();
      int         acc_pop[$];
      logic [7:0] acc_data[$];
      int         last_pop = -100000;
      bit         dropped  = 1'b0;
      int         p, occ, pp;
      logic [7:0] b, d;
      logic       h;
      clear_rx();
      for (int n = 0; n < 24; n++) begin
         b = 8'($urandom);
         do_write(8'hF0, b, $urandom_range(1, 3), p);
         occ = 0;
         foreach (acc_pop[j]) if (acc_pop[j] >= p) occ++;
         if (occ < DEPTH) begin
            pp       = (p + 1 > last_pop + FRAME + 1) ? p + 1 : last_pop + FRAME + 1;
            last_pop = pp;
            acc_pop.push_back(pp);
            acc_data.push_back(b);
         end else begin
            dropped = 1'b1;
         end
         if ($urandom_range(0, 3) == 0) read_reg(8'hF1, 1'b0, d, h);
         repeat ($urandom_range(0, 40)) @(negedge clock);
      end
      wait_frames(acc_data.size(), (DEPTH + 2) * (FRAME + 1) + 50);
      repeat (FRAME + 10) @(negedge clock);
      chk_cnt++;
      if (rx_byte.size() != acc_data.size())
         $display("FAIL rand_count: got %0d expected %0d", rx_byte.size(), acc_data.size());
      else pass_cnt++;
      for (int i = 0; i < acc_data.size() && i < rx_byte.size(); i++) begin
         chk_cnt++;
         if ({rx_bad[i], rx_byte[i]} !== {1'b0, acc_data[i]} || rx_start[i] != acc_pop[i])
            $display("FAIL rand_frame%0d: got bad=%0d data=%h start=%0d expected %h at %0d",
                     i, rx_bad[i], rx_byte[i], rx_start[i], acc_data[i], acc_pop[i]);
         else pass_cnt++;
      end
      read_reg(8'hF1, 1'b0, d, h);
      chk_cnt++;
      if ({h, d} !== {1'b1, dropped, 7'h08})
         $display("FAIL rand_status: got %h expected %h", {h, d}, {1'b1, dropped, 7'h08});
      else pass_cnt++;
      do_write(8'hF1, 8'h00, 1, p);
      read_reg(8'hF1, 1'b0, d, h);
      chk_cnt++;
      if ({h, d} !== 9'h108) $display("FAIL rand_clear: got %h expected 108", {h, d});
      else pass_cnt++;
   endtask

   task automatic test_idle_line();
      chk_cnt++;
      if (idle_bad != 0) $display("FAIL idle_line: got %0d bad idle cycles expected 0", idle_bad);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_long_strobe();
      test_back_to_back();
      test_reset_mid();
      test_read_decode();
      test_random();
      test_idle_line();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/cdec8_tx_port.md
CDEC8_TX_PORT -- requirements
Module: cdec8_tx_port

Interface
REQ-001 The block SHALL have parameter BASE_ADRS, default 8'hF0: address of TXDATA; STATUS is at BASE_ADRS+1.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 434: clock cycles per serial bit, legal range 2..65535.
REQ-003 The block SHALL have parameter FIFO_AW, default 3: log2 of FIFO depth, so the default depth is 8 entries.
REQ-004 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous reset, active-high.
REQ-006 adrs  in  8  CPU memory address.
REQ-007 wr_data  in  8  CPU write data.
REQ-008 mmwr_N  in  1  CPU write strobe, active-low, may stay low for several cycles.
REQ-009 mmrd_N  in  1  CPU read strobe, active-low.
REQ-010 rd_data  out  8  read data to the CPU bus mux.
REQ-011 rd_hit  out  1  high when rd_data is valid for this block.
REQ-012 txd  out  1  serial output, idle high.
REQ-013 busy  out  1  high while a frame is being shifted out.

Function
REQ-014 The block SHALL sit on the CPU memory bus downstream of the CPU core, mapping a transmit FIFO and a serial shifter to two addresses.
REQ-015 Write detect: a registered copy wr_prev of mmwr_N SHALL exist; a write event SHALL occur at an edge where mmwr_N==0 and wr_prev==1, giving exactly one event per strobe regardless of strobe length.
REQ-016 A write event with adrs==BASE_ADRS SHALL push wr_data into the FIFO if it is not full; if it is full, the data SHALL be dropped and sticky ovf SHALL be set.
REQ-017 A write event with adrs==BASE_ADRS+1 SHALL clear ovf; wr_data SHALL be ignored.
REQ-018 Full SHALL be evaluated before any same-cycle pop, so a push to a full FIFO is dropped even when a pop occurs on the same edge.
REQ-019 The FIFO SHALL use FIFO_AW-bit read/write pointers that wrap modulo depth and a FIFO_AW+1-bit count; full when count==depth, empty when count==0.
REQ-020 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave count unchanged.
REQ-021 Read path, combinational: with mmrd_N==0 and adrs==BASE_ADRS+1, rd_hit SHALL be 1 and rd_data SHALL be {ovf,3'b000,count==0,full,busy,1'b0} (bit7 ovf, bit3 empty, bit2 full, bit1 busy).
REQ-022 With mmrd_N==0 and adrs==BASE_ADRS, rd_hit SHALL be 1 and rd_data SHALL be 8'h00.
REQ-023 Otherwise rd_hit SHALL be 0 and rd_data SHALL be 8'h00.
REQ-024 Reads SHALL have no side effects.
REQ-025 The shifter FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-026 IDLE: txd SHALL be 1; when the FIFO is not empty, the FSM SHALL pop the head into an 8-bit shift register, load the baud counter with CLKS_PER_BIT-1 and go to START.
REQ-027 START: txd SHALL be 0 for CLKS_PER_BIT cycles, then the FSM SHALL go to DATA with bit index 0.
REQ-028 DATA: txd SHALL be the shift register LSB; each bit SHALL last CLKS_PER_BIT cycles; after bit 7 the FSM SHALL go to STOP.
REQ-029 STOP: txd SHALL be 1 for CLKS_PER_BIT cycles, then the FSM SHALL go to IDLE.
REQ-030 The baud counter SHALL count down, and a bit SHALL end at the edge where the counter==0, which reloads it.
REQ-031 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-032 txd SHALL be driven from a register with no combinational glitches.
REQ-033 Latency: txd SHALL fall at the second rising edge after the write-detect edge (one edge to push, one edge to pop and enter START).
REQ-034 A full frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-035 Back-to-back frames: from STOP to IDLE to START SHALL add exactly one idle cycle (txd=1) between frames when the FIFO is non-empty.
REQ-036 Writes during a frame SHALL only enqueue and SHALL never disturb the frame in progress.

Reset
REQ-037 Reset assertion SHALL immediately force the FSM to IDLE, txd=1, busy=0, FIFO pointers and count=0, ovf=0, wr_prev=1 and the baud counter=0, regardless of clock.
REQ-038 Reset asserted mid-frame SHALL abort the frame, and the FIFO contents SHALL be discarded.
REQ-039 After reset release, the block SHALL behave identically to power-up.

Verification (CLKS_PER_BIT=4, FIFO_AW=2)
REQ-040 Write 8'hA5 to F0 -> txd low at 2nd edge after detect, then bits 1,0,1,0,0,1,0,1 each 4 cycles, then high for 4 cycles; busy high for 40 cycles.
REQ-041 Hold mmwr_N low for 10 cycles at F0 with 8'h55 -> exactly one frame is sent.
REQ-042 Write 6 bytes rapidly -> 1 popped into the shifter plus 4 queued are accepted, the 6th is dropped; STATUS reads 8'h86 during the frame (ovf, full, busy); frames are separated by 1 idle cycle.
REQ-043 Write to F1 -> ovf clears; STATUS after all frames finish reads 8'h08.
REQ-044 Assert reset in the DATA state -> txd=1 and busy=0 immediately; STATUS reads 8'h08; no further frames.
REQ-045 Read F2 or read with mmrd_N=1 -> rd_hit=0 and rd_data=8'h00.
